// File: rtl/ofdm_pilot_demux.sv
//============================================================================
// Module   : ofdm_pilot_demux
// Summary  : Forwards each FFT beat on a data stream, extracts one pilot per
//            beat in a subcarrier window, tracks symbol framing.
// Options  : PILOT_DEMUX_TLAST_CHECK_EN - honour s_axis_tlast for framing.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module ofdm_pilot_demux #(
  parameter int SAMPLE_W      = 16,
  parameter int LANES         = 4,
  parameter int BEATS_PER_SYM = 256,
  parameter int PILOT_LANE    = 3,
  parameter int PILOT_FIRST   = 27,
  parameter int PILOT_LAST    = 227,
  parameter int CNT_W         = $clog2(BEATS_PER_SYM)
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        bypass,

  input  logic [2*SAMPLE_W*LANES-1:0] s_axis_tdata,
  input  logic                        s_axis_tlast,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,

  output logic [2*SAMPLE_W*LANES-1:0] m_data_axis_tdata,
  output logic                        m_data_axis_tlast,
  output logic                        m_data_axis_tvalid,
  input  logic                        m_data_axis_tready,

  output logic [2*SAMPLE_W-1:0]       m_pilot_axis_tdata,
  output logic [CNT_W-1:0]            m_pilot_axis_tuser,
  output logic                        m_pilot_axis_tlast,
  output logic                        m_pilot_axis_tvalid,
  input  logic                        m_pilot_axis_tready,

  output logic [15:0]                 sym_count,
  output logic                        tlast_err
);

  localparam int               c_data_w    = 2*SAMPLE_W*LANES;
  localparam int               c_pilot_w   = 2*SAMPLE_W;
  localparam logic [CNT_W-1:0] c_last_beat = CNT_W'(BEATS_PER_SYM-1);
  localparam logic [CNT_W-1:0] c_pil_first = CNT_W'(PILOT_FIRST);
  localparam logic [CNT_W-1:0] c_pil_last  = CNT_W'(PILOT_LAST);

`ifdef PILOT_DEMUX_TLAST_CHECK_EN
  localparam logic c_tlast_check = 1'b1;
`else
  localparam logic c_tlast_check = 1'b0;
`endif

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_byp_q;
  logic [c_data_w-1:0]   r_data_tdata;
  logic                  r_data_tlast;
  logic                  r_data_tvalid;
  logic [c_pilot_w-1:0]  r_pilot_tdata;
  logic [CNT_W-1:0]      r_pilot_tuser;
  logic                  r_pilot_tlast;
  logic                  r_pilot_tvalid;
  logic [15:0]           r_sym_count;
  logic                  r_tlast_err;

  logic                  w_ready;
  logic                  w_accept;
  logic                  w_tlast_in;
  logic                  w_last_beat;
  logic                  w_eos;
  logic                  w_err;
  logic                  w_byp_eff;
  logic                  w_in_window;
  logic                  w_emit_pilot;
  logic [c_pilot_w-1:0]  w_pilot_lane;

  // Both outputs load together, so the input may only move when neither
  // output is holding an unconsumed beat.
  assign w_ready = !areset
                 && (!r_data_tvalid  || m_data_axis_tready)
                 && (!r_pilot_tvalid || m_pilot_axis_tready);

  assign w_accept     = s_axis_tvalid && w_ready;
  assign w_tlast_in   = c_tlast_check && s_axis_tlast;
  assign w_last_beat  = (r_cnt == c_last_beat);
  assign w_eos        = w_tlast_in || w_last_beat;
  assign w_err        = c_tlast_check && (w_tlast_in != w_last_beat);
  // The first beat of a symbol already uses the freshly sampled bypass.
  assign w_byp_eff    = (r_state == IDLE) ? bypass : r_byp_q;
  assign w_in_window  = (r_cnt >= c_pil_first) && (r_cnt <= c_pil_last);
  assign w_emit_pilot = w_in_window && !w_byp_eff;
  assign w_pilot_lane = s_axis_tdata[PILOT_LANE*c_pilot_w +: c_pilot_w];

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_byp_q        <= 1'b0;
      r_data_tdata   <= '0;
      r_data_tlast   <= 1'b0;
      r_data_tvalid  <= 1'b0;
      r_pilot_tdata  <= '0;
      r_pilot_tuser  <= '0;
      r_pilot_tlast  <= 1'b0;
      r_pilot_tvalid <= 1'b0;
      r_sym_count    <= '0;
      r_tlast_err    <= 1'b0;
    end else begin
      r_tlast_err <= w_accept && w_err;

      if (w_accept) begin
        r_data_tdata   <= s_axis_tdata;
        r_data_tlast   <= w_eos;
        r_data_tvalid  <= 1'b1;
        r_pilot_tvalid <= w_emit_pilot;
        if (w_emit_pilot) begin
          r_pilot_tdata <= w_pilot_lane;
          r_pilot_tuser <= r_cnt;
          r_pilot_tlast <= (r_cnt == c_pil_last) || w_tlast_in;
        end

        if (w_eos) begin
          r_cnt       <= '0;
          r_sym_count <= r_sym_count + 16'd1;
        end else begin
          r_cnt       <= r_cnt + CNT_W'(1);
        end

        case (r_state)
          IDLE: begin
            r_byp_q <= bypass;
            r_state <= w_eos ? IDLE : ACTIVE;
          end
          ACTIVE: begin
            if (w_eos) begin
              r_state <= IDLE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end else begin
        if (m_data_axis_tready) begin
          r_data_tvalid <= 1'b0;
        end
        if (m_pilot_axis_tready) begin
          r_pilot_tvalid <= 1'b0;
        end
      end
    end
  end

  assign s_axis_tready       = w_ready;
  assign m_data_axis_tdata   = r_data_tdata;
  assign m_data_axis_tlast   = r_data_tlast;
  assign m_data_axis_tvalid  = r_data_tvalid;
  assign m_pilot_axis_tdata  = r_pilot_tdata;
  assign m_pilot_axis_tuser  = r_pilot_tuser;
  assign m_pilot_axis_tlast  = r_pilot_tlast;
  assign m_pilot_axis_tvalid = r_pilot_tvalid;
  assign sym_count           = r_sym_count;
  assign tlast_err           = r_tlast_err;

endmodule

`default_nettype wire

// File: tb/tb_ofdm_pilot_demux.sv
//============================================================================
// Module   : tb_ofdm_pilot_demux
// Summary  : Randomised bench for ofdm_pilot_demux against a symbol-level
//            reference model; follows PILOT_DEMUX_TLAST_CHECK_EN if defined.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_ofdm_pilot_demux;

  localparam int SAMPLE_W = 16;
  localparam int LANES    = 4;
  localparam int BPS      = 256;
  localparam int PL       = 3;
  localparam int PF       = 27;
  localparam int PLAST    = 227;
  localparam int CNT_W    = 8;
  localparam int DW       = 2*SAMPLE_W*LANES;
  localparam int PW       = 2*SAMPLE_W;

`ifdef PILOT_DEMUX_TLAST_CHECK_EN
  localparam bit TLAST_EN = 1'b1;
`else
  localparam bit TLAST_EN = 1'b0;
`endif

  logic             aclk = 1'b0;
  logic             areset = 1'b1;
  logic             bypass = 1'b0;
  logic [DW-1:0]    s_axis_tdata = '0;
  logic             s_axis_tlast = 1'b0;
  logic             s_axis_tvalid = 1'b0;
  logic             s_axis_tready;
  logic [DW-1:0]    m_data_axis_tdata;
  logic             m_data_axis_tlast;
  logic             m_data_axis_tvalid;
  logic             m_data_axis_tready = 1'b1;
  logic [PW-1:0]    m_pilot_axis_tdata;
  logic [CNT_W-1:0] m_pilot_axis_tuser;
  logic             m_pilot_axis_tlast;
  logic             m_pilot_axis_tvalid;
  logic             m_pilot_axis_tready = 1'b1;
  logic [15:0]      sym_count;
  logic             tlast_err;

  ofdm_pilot_demux #(
    .SAMPLE_W(SAMPLE_W), .LANES(LANES), .BEATS_PER_SYM(BPS),
    .PILOT_LANE(PL), .PILOT_FIRST(PF), .PILOT_LAST(PLAST), .CNT_W(CNT_W)
  ) dut (
    .aclk(aclk), .areset(areset), .bypass(bypass),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_data_axis_tdata(m_data_axis_tdata), .m_data_axis_tlast(m_data_axis_tlast),
    .m_data_axis_tvalid(m_data_axis_tvalid), .m_data_axis_tready(m_data_axis_tready),
    .m_pilot_axis_tdata(m_pilot_axis_tdata), .m_pilot_axis_tuser(m_pilot_axis_tuser),
    .m_pilot_axis_tlast(m_pilot_axis_tlast), .m_pilot_axis_tvalid(m_pilot_axis_tvalid),
    .m_pilot_axis_tready(m_pilot_axis_tready),
    .sym_count(sym_count), .tlast_err(tlast_err)
  );

  always #5 aclk = ~aclk;

  typedef struct { logic [DW-1:0] d; logic l; } dexp_t;
  typedef struct { logic [PW-1:0] d; logic [CNT_W-1:0] u; logic l; } pexp_t;

  dexp_t dq[$];
  pexp_t pq[$];
  int    n_tests = 0;
  int    n_fail = 0;
  int    n_pilots = 0;
  int    n_errs = 0;
  int    n_data = 0;
  int    ready_mode = 0;
  bit    gap_en = 1'b0;

  // Reference model: position within the current symbol and its bypass.
  int    m_pos = 0;
  int    m_sym = 0;
  bit    m_byp = 1'b0;
  bit    m_err_next = 1'b0;
  bit    mt_tl, mt_lastb, mt_eos;
  dexp_t de;
  pexp_t pe;

  bit            hold_d_v = 1'b0;
  logic [DW-1:0] hold_d;
  logic          hold_dl;
  bit            hold_p_v = 1'b0;
  logic [PW-1:0] hold_p;
  logic [CNT_W-1:0] hold_pu;
  logic          hold_pl;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge aclk) begin
    #1;
    case (ready_mode)
      0: begin
        m_data_axis_tready  = 1'b1;
        m_pilot_axis_tready = 1'b1;
      end
      1: begin
        m_pilot_axis_tready = ~m_pilot_axis_tready;
        m_data_axis_tready  = 1'($urandom_range(0, 1));
      end
      default: begin
        m_pilot_axis_tready = ($urandom_range(0, 3) != 0);
        m_data_axis_tready  = ($urandom_range(0, 3) != 0);
      end
    endcase
  end

  always @(negedge aclk) begin
    if (areset) begin
      dq.delete();
      pq.delete();
      m_pos = 0;
      m_sym = 0;
      m_byp = 1'b0;
      m_err_next = 1'b0;
      hold_d_v = 1'b0;
      hold_p_v = 1'b0;
    end else begin
      check_eq("s_axis_tready", s_axis_tready,
               (!m_data_axis_tvalid || m_data_axis_tready) &&
               (!m_pilot_axis_tvalid || m_pilot_axis_tready));
      check_eq("tlast_err", tlast_err, m_err_next);
      if (tlast_err) n_errs++;
      check_eq("sym_count", sym_count, m_sym[15:0]);

      if (hold_d_v) begin
        check_eq("data_hold_valid", m_data_axis_tvalid, 1'b1);
        check_eq("data_hold_tdata", m_data_axis_tdata, hold_d);
        check_eq("data_hold_tlast", m_data_axis_tlast, hold_dl);
      end
      if (hold_p_v) begin
        check_eq("pilot_hold_valid", m_pilot_axis_tvalid, 1'b1);
        check_eq("pilot_hold_tdata", m_pilot_axis_tdata, hold_p);
        check_eq("pilot_hold_tuser", m_pilot_axis_tuser, hold_pu);
        check_eq("pilot_hold_tlast", m_pilot_axis_tlast, hold_pl);
      end
      hold_d_v = m_data_axis_tvalid && !m_data_axis_tready;
      hold_d   = m_data_axis_tdata;
      hold_dl  = m_data_axis_tlast;
      hold_p_v = m_pilot_axis_tvalid && !m_pilot_axis_tready;
      hold_p   = m_pilot_axis_tdata;
      hold_pu  = m_pilot_axis_tuser;
      hold_pl  = m_pilot_axis_tlast;

      if (m_data_axis_tvalid && m_data_axis_tready) begin
        if (dq.size() == 0) begin
          check_eq("data_unexpected", m_data_axis_tvalid, 1'b0);
        end else begin
          de = dq.pop_front();
          check_eq("data_tdata", m_data_axis_tdata, de.d);
          check_eq("data_tlast", m_data_axis_tlast, de.l);
          n_data++;
        end
      end
      if (m_pilot_axis_tvalid && m_pilot_axis_tready) begin
        if (pq.size() == 0) begin
          check_eq("pilot_unexpected", m_pilot_axis_tvalid, 1'b0);
        end else begin
          pe = pq.pop_front();
          check_eq("pilot_tdata", m_pilot_axis_tdata, pe.d);
          check_eq("pilot_tuser", m_pilot_axis_tuser, pe.u);
          check_eq("pilot_tlast", m_pilot_axis_tlast, pe.l);
          n_pilots++;
        end
      end

      if (s_axis_tvalid && s_axis_tready) begin
        mt_tl    = TLAST_EN && s_axis_tlast;
        mt_lastb = (m_pos == BPS-1);
        mt_eos   = mt_tl || mt_lastb;
        if (m_pos == 0) m_byp = bypass;
        de.d = s_axis_tdata;
        de.l = mt_eos;
        dq.push_back(de);
        if (!m_byp && m_pos >= PF && m_pos <= PLAST) begin
          pe.d = s_axis_tdata[PL*PW +: PW];
          pe.u = m_pos[CNT_W-1:0];
          pe.l = (m_pos == PLAST) || mt_tl;
          pq.push_back(pe);
        end
        m_err_next = TLAST_EN && (mt_tl != mt_lastb);
        if (mt_eos) begin
          m_sym++;
          m_pos = 0;
        end else begin
          m_pos++;
        end
      end else begin
        m_err_next = 1'b0;
      end
    end
  end

  task automatic send_beat(input int k, input bit tl);
    int  waited;
    bit  acc;
    if (gap_en && $urandom_range(0, 3) == 0) begin
      s_axis_tvalid = 1'b0;
      repeat ($urandom_range(1, 2)) @(posedge aclk);
      #1;
    end
    s_axis_tdata = {$urandom, $urandom, $urandom, $urandom};
    s_axis_tdata[PL*PW +: PW] = {16'(-k), 16'(k)};
    s_axis_tlast  = tl;
    s_axis_tvalid = 1'b1;
    waited = 0;
    forever begin
      @(negedge aclk);
      acc = s_axis_tready;
      @(posedge aclk);
      #1;
      if (acc) break;
      waited++;
      if (waited > 200) begin
        check_eq("input_timeout", s_axis_tready, 1'b1);
        break;
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic do_reset(input int n);
    areset = 1'b1;
    s_axis_tvalid = 1'b0;
    repeat (n) @(posedge aclk);
    #1;
    check_eq("rst_data_tvalid", m_data_axis_tvalid, 1'b0);
    check_eq("rst_pilot_tvalid", m_pilot_axis_tvalid, 1'b0);
    check_eq("rst_data_tdata", m_data_axis_tdata, '0);
    check_eq("rst_data_tlast", m_data_axis_tlast, 1'b0);
    check_eq("rst_pilot_tdata", m_pilot_axis_tdata, '0);
    check_eq("rst_pilot_tuser", m_pilot_axis_tuser, '0);
    check_eq("rst_pilot_tlast", m_pilot_axis_tlast, 1'b0);
    check_eq("rst_tlast_err", tlast_err, 1'b0);
    check_eq("rst_sym_count", sym_count, '0);
    check_eq("rst_s_tready", s_axis_tready, 1'b0);
    areset = 1'b0;
    n_pilots = 0;
    n_errs   = 0;
    n_data   = 0;
  endtask

  task automatic drain(input string tag);
    ready_mode = 0;
    repeat (6) @(posedge aclk);
    #1;
    check_eq({tag, "_data_left"}, dq.size(), 0);
    check_eq({tag, "_pilot_left"}, pq.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Nominal two symbols, no stalls
    do_reset(2);
    ready_mode = 0; gap_en = 1'b0; bypass = 1'b0;
    for (int k = 0; k < 2*BPS; k++) send_beat(k, (k % BPS) == BPS-1);
    drain("nominal");
    check_eq("nominal_pilots", n_pilots, 402);
    check_eq("nominal_data", n_data, 512);
    check_eq("nominal_sym", sym_count, 2);
    check_eq("nominal_errs", n_errs, 0);

    // Same stream under backpressure
    do_reset(2);
    ready_mode = 1; gap_en = 1'b1;
    for (int k = 0; k < 2*BPS; k++) send_beat(k, (k % BPS) == BPS-1);
    drain("bp");
    check_eq("bp_pilots", n_pilots, 402);
    check_eq("bp_sym", sym_count, 2);

    // Early tlast at beat 99
    do_reset(2);
    ready_mode = 0; gap_en = 1'b0;
    for (int k = 0; k < 100 + BPS; k++) send_beat(k, k == 99 || k == 99 + BPS);
    drain("early");
    check_eq("early_pilots", n_pilots, 274);
    check_eq("early_errs", n_errs, TLAST_EN ? 1 : 0);
    check_eq("early_sym", sym_count, TLAST_EN ? 2 : 1);

    // Missing tlast on beat 255
    do_reset(2);
    for (int k = 0; k < 2*BPS; k++) send_beat(k, k == 2*BPS-1);
    drain("missing");
    check_eq("missing_pilots", n_pilots, 402);
    check_eq("missing_errs", n_errs, TLAST_EN ? 1 : 0);
    check_eq("missing_sym", sym_count, 2);

    // Bypass raised mid symbol 0, dropped mid symbol 1
    do_reset(2);
    for (int k = 0; k < 3*BPS; k++) begin
      if (k == 100) bypass = 1'b1;
      if (k == 400) bypass = 1'b0;
      send_beat(k, (k % BPS) == BPS-1);
    end
    drain("bypass");
    check_eq("bypass_pilots", n_pilots, 402);
    check_eq("bypass_sym", sym_count, 3);

    // Reset at beat 150, then a fresh symbol
    do_reset(2);
    for (int k = 0; k < 150; k++) send_beat(k, 1'b0);
    do_reset(2);
    for (int k = 0; k < BPS; k++) send_beat(k, k == BPS-1);
    drain("rstmid");
    check_eq("rstmid_pilots", n_pilots, 201);
    check_eq("rstmid_sym", sym_count, 1);

    // Random framing, bypass and stalls
    do_reset(2);
    ready_mode = 2; gap_en = 1'b1;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 49) == 0) bypass = ~bypass;
      send_beat(k, $urandom_range(0, 63) == 0);
    end
    drain("random");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ofdm_pilot_demux.md
# ofdm_pilot_demux

Parametrised front-end splitter for the zero-forcing equalizer datapath. It accepts the multi-lane FFT output stream, one OFDM symbol of `BEATS_PER_SYM` beats per frame, and forwards every beat unchanged on a data stream. In parallel it extracts one complex pilot per beat from a configurable lane, inside a configurable active-subcarrier window, onto a separate pilot stream that feeds the channel estimator. It tracks symbol framing, resynchronises on framing errors and counts symbols.

## Interface
- `SAMPLE_W`, 16: width of one I or Q component.
- `LANES`, 4: complex samples per input beat.
- `BEATS_PER_SYM`, 256: beats per OFDM symbol.
- `PILOT_LANE`, 3: lane index (0-based) carrying pilots.
- `PILOT_FIRST`, 27: first beat index emitted as pilot.
- `PILOT_LAST`, 227: last beat index emitted as pilot; requires `PILOT_FIRST <= PILOT_LAST < BEATS_PER_SYM`.
- `CNT_W`, `$clog2(BEATS_PER_SYM)`: beat index width.

Ports:
- `aclk`  in  1  clock.
- `areset`  in  1  synchronous, active-high reset.
- `bypass`  in  1  suppress pilot extraction; latched per symbol.
- `s_axis_tdata`  in  `2*SAMPLE_W*LANES`  lane k at `[k*2*SAMPLE_W +: 2*SAMPLE_W]`, as {Q,I} with I in the low half.
- `s_axis_tlast`  in  1  end of symbol.
- `s_axis_tvalid`  in  1.
- `s_axis_tready`  out  1.
- `m_data_axis_tdata`  out  `2*SAMPLE_W*LANES`  input beat, unchanged.
- `m_data_axis_tlast`, `m_data_axis_tvalid`  out  1 each.
- `m_data_axis_tready`  in  1.
- `m_pilot_axis_tdata`  out  `2*SAMPLE_W`  {Q,I} of `PILOT_LANE`.
- `m_pilot_axis_tuser`  out  `CNT_W`  beat index of the pilot.
- `m_pilot_axis_tlast`, `m_pilot_axis_tvalid`  out  1 each.
- `m_pilot_axis_tready`  in  1.
- `sym_count`  out  16  completed symbols; wraps at 2^16.
- `tlast_err`  out  1  one-cycle framing-error pulse.

## Operation
- Beat counter `cnt` (0..BEATS_PER_SYM-1) advances on each accepted input beat (`s_axis_tvalid && s_axis_tready`).
- Two states:
  - IDLE (`cnt==0`): on an accepted beat, latch `bypass` into `byp_q` and go to ACTIVE.
  - ACTIVE: at end of symbol, `cnt` returns to 0, `sym_count` increments and the state returns to IDLE.
- Data path:
  - Every accepted beat is registered onto `m_data_axis`.
  - `m_data_axis_tlast` = (`cnt==BEATS_PER_SYM-1`) OR `s_axis_tlast`.
- Pilot path:
  - Emitted when `!byp_q` and `PILOT_FIRST <= cnt <= PILOT_LAST`, with `tuser = cnt`.
  - `m_pilot_axis_tlast` = (`cnt==PILOT_LAST`) OR (`s_axis_tlast` inside the window).
- Backpressure: `s_axis_tready` = `!areset && (!m_data_axis_tvalid || m_data_axis_tready) && (!m_pilot_axis_tvalid || m_pilot_axis_tready)`. Both outputs advance jointly, so no beat is lost or reordered.
- End-of-symbol event is `s_axis_tlast` OR `cnt==BEATS_PER_SYM-1`.
- Early `s_axis_tlast` (`cnt < BEATS_PER_SYM-1`):
  - `tlast_err` pulses.
  - The symbol is closed and `cnt` resets to 0.
  - `sym_count` increments.
- Missing tlast (`cnt==BEATS_PER_SYM-1` without `s_axis_tlast`):
  - `tlast_err` pulses.
  - `cnt` wraps to 0.
  - Data tlast is still asserted.
- `bypass` changes take effect only at the first beat of the next symbol.

## Timing
- Latency: accepted input beat to output valid is 1 cycle. `tlast_err` asserts in the same cycle as that output beat.
- Throughput: 1 beat/cycle with both readies high.
- Output valids hold, with stable data, until their ready is seen.
- Reset value of all outputs:
  - All valids, tlasts and `tlast_err` = 0.
  - All tdata and tuser = 0.
  - `sym_count` = 0.
  - `s_axis_tready` = 0 while `areset` is high.
  - Internal: `cnt` = 0, state IDLE, `byp_q` = 0.
- Reset mid-symbol: the partial symbol is discarded and pending outputs are dropped. The first beat accepted after reset is beat 0.
- `tlast_err` never asserts for two consecutive cycles unless two consecutive beats are errored.

## Configuration
- `PILOT_DEMUX_TLAST_CHECK_EN`:
  - Defined: `s_axis_tlast` is honoured, with early-tlast resync and `tlast_err` as above.
  - Undefined: `s_axis_tlast` is ignored. Framing comes purely from `cnt`, both tlast outputs are counter-derived only, and `tlast_err` is tied to 0.

## Test plan
- Nominal: 2 symbols × 256 beats, lane 3 = {Q=-k, I=k} for beat k, tlast on beats 255/511, readies 1, bypass 0. Required:
  - 402 pilots, tuser 27..227 per symbol, pilot tlast on tuser 227.
  - Data tlast on output beats 255 and 511.
  - `sym_count`=2, `tlast_err` never asserts.
- Backpressure: `m_pilot_axis_tready` toggles 1/0 and `m_data_axis_tready` is random. Required:
  - `s_axis_tready` drops whenever an output is stalled.
  - Data and pilot sequences bit-identical to the nominal case.
- Early tlast at beat 99: `tlast_err` pulses once, pilot tlast on tuser 99, and the next beat is treated as beat 0 (next pilot tuser 27). `sym_count` increments.
- Missing tlast on beat 255: `tlast_err` pulses with output beat 255, data tlast is still 1 on that beat, and the next symbol counts from 0.
- Bypass: assert `bypass` at beat 100 of symbol 0. Required:
  - Pilots continue through tuser 227 for symbol 0.
  - Symbol 1 emits 0 pilots.
  - Deasserting bypass restores pilots from symbol 2.
- Reset at beat 150 for 2 cycles: all valids are 0 the cycle after reset, `sym_count`=0, and a fresh symbol yields tuser 27..227 normally.
